spi_reg_bridge_ctrl: RTL

// Command sequencer between the SPI byte slave and an internal 8-bit register bus.

---
 rtl/spi_reg_bridge_ctrl.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bridge_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_reg_bridge_ctrl
//  Brief    : Command sequencer between an SPI byte slave and an 8-bit
//             register bus. Each chip-select frame is CMD, ADDR, DATA...;
//             data bytes become bus writes, or reads whose results are fed
//             back to the slave transmit register. A status byte is preloaded
//             into the slave every time the sequencer returns to idle.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_reg_bridge_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_frame_act,
  input  logic              spi_rx_valid,
  input  logic [7:0]        spi_rx_data,
  output logic              spi_tx_valid,
  output logic [7:0]        spi_tx_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack,
  output logic              err
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_CMD        = 4'd1,
    S_ADDR       = 4'd2,
    S_WR_DATA    = 4'd3,
    S_WR_WAIT    = 4'd4,
    S_RD_REQ     = 4'd5,
    S_RD_WAIT    = 4'd6,
    S_RD_PRESENT = 4'd7,
    S_DRAIN      = 4'd8,
    S_ABORT_WAIT = 4'd9
  } state_t;

  // Last counter value before the request is abandoned (request lasts TIMEOUT cycles)
  localparam logic [15:0] C_TMO_LAST = 16'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                act_prev_q, act_prev_d;
  logic                pend_q, pend_d;          // status preload owed to the slave
  logic                tx_valid_q, tx_valid_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                err_q, err_d;
  logic                last_ok_q, last_ok_d;
  logic                frame_err_q, frame_err_d; // any error seen in the current frame
  logic                rd_q, rd_d;
  logic                inc_q, inc_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                w_ack;
  logic                w_tmo;
  logic                w_to_idle;
  logic [ADDR_W-1:0]   w_addr_in;

  // Address byte is zero-extended or truncated to the bus address width
  generate
    if (ADDR_W > 8) begin : g_addr_ext
      assign w_addr_in = {{(ADDR_W-8){1'b0}}, spi_rx_data};
    end else begin : g_addr_trunc
      assign w_addr_in = spi_rx_data[ADDR_W-1:0];
    end
  endgenerate

  // An ack only counts while a request is outstanding; ack beats timeout expiry
  assign w_ack = req_q & bus_ack;
  assign w_tmo = req_q & ~bus_ack & (cnt_q == C_TMO_LAST);

  // Next-state and datapath computation for the whole sequencer
  always_comb begin
    state_d     = state_q;
    act_prev_d  = spi_frame_act;
    pend_d      = pend_q;
    tx_valid_d  = 1'b0;
    tx_data_d   = tx_data_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    last_ok_d   = last_ok_q;
    frame_err_d = frame_err_q;
    rd_d        = rd_q;
    inc_d       = inc_q;
    cnt_d       = cnt_q;
    w_to_idle   = 1'b0;

    // Bus handshake bookkeeping is shared by every state holding a request
    if (req_q) begin
      if (w_ack || w_tmo) begin
        req_d = 1'b0;
        cnt_d = 16'd0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
    if (w_tmo) begin
      err_d       = 1'b1;
      frame_err_d = 1'b1;
    end

    if (pend_q) begin
      tx_valid_d = 1'b1;
      tx_data_d  = {err_q, 6'b0, last_ok_q};
      pend_d     = 1'b0;
    end

    if (state_q == S_IDLE) begin
      // Rising edge only: a frame that began during ABORT_WAIT is never picked up
      if (spi_frame_act && !act_prev_q) begin
        state_d     = S_CMD;
        frame_err_d = 1'b0;
      end
    end else if (state_q == S_ABORT_WAIT) begin
      if (!req_q || w_ack || w_tmo) begin
        w_to_idle = 1'b1;
      end
    end else if (!spi_frame_act) begin
      // Frame end wins over any byte arriving in the same cycle
      if (req_q && !w_ack && !w_tmo) begin
        state_d = S_ABORT_WAIT;
      end else begin
        w_to_idle = 1'b1;
      end
    end else begin
      case (state_q)
        S_CMD: begin
          if (spi_rx_valid) begin
            if (spi_rx_data[5]) begin
              err_d = 1'b0;
            end
            rd_d  = spi_rx_data[7];
            inc_d = spi_rx_data[6];
            if (spi_rx_data[4:0] != 5'd0) begin
              err_d       = 1'b1;
              frame_err_d = 1'b1;
              state_d     = S_DRAIN;
            end else begin
              state_d = S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (spi_rx_valid) begin
            addr_d = w_addr_in;
            if (rd_q) begin
              req_d   = 1'b1;
              we_d    = 1'b0;
              state_d = S_RD_REQ;
            end else begin
              state_d = S_WR_DATA;
            end
          end
        end
        S_WR_DATA: begin
          if (spi_rx_valid) begin
            wdata_d = spi_rx_data;
            we_d    = 1'b1;
            req_d   = 1'b1;
            state_d = S_WR_WAIT;
          end
        end
        S_WR_WAIT, S_RD_REQ, S_RD_WAIT: begin
          // Byte arriving mid-transaction is lost; the transaction itself carries on
          if (spi_rx_valid) begin
            err_d       = 1'b1;
            frame_err_d = 1'b1;
          end
          if (w_ack) begin
            if (inc_q) begin
              addr_d = addr_q + 1'b1;
            end
            if (state_q == S_WR_WAIT) begin
              state_d = S_WR_DATA;
            end else begin
              tx_valid_d = 1'b1;
              tx_data_d  = bus_rdata;
              state_d    = S_RD_PRESENT;
            end
          end else if (w_tmo) begin
            state_d = S_DRAIN;
          end else if (state_q == S_RD_REQ) begin
            state_d = S_RD_WAIT;
          end
        end
        S_RD_PRESENT: begin
          // The master clocking a byte out means it consumed the read data
          if (spi_rx_valid) begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            state_d = S_RD_REQ;
          end
        end
        S_DRAIN: begin
          state_d = S_DRAIN;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (w_to_idle) begin
      state_d   = S_IDLE;
      pend_d    = 1'b1;
      last_ok_d = ~frame_err_d;
    end
  end

  // State and output registers; pend starts set so a status byte follows reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      act_prev_q  <= 1'b0;
      pend_q      <= 1'b1;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 8'd0;
      err_q       <= 1'b0;
      last_ok_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rd_q        <= 1'b0;
      inc_q       <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      act_prev_q  <= act_prev_d;
      pend_q      <= pend_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      last_ok_q   <= last_ok_d;
      frame_err_q <= frame_err_d;
      rd_q        <= rd_d;
      inc_q       <= inc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign spi_tx_valid = tx_valid_q;
  assign spi_tx_data  = tx_data_q;
  assign bus_req      = req_q;
  assign bus_we       = we_q;
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;
  assign err          = err_q;

endmodule
`default_nettype wire
